// File: rtl/mult_sequencer.sv
// Shift-and-add unsigned multiplier that borrows the shared ALU adder through a req/gnt port.
// Optional MULT_SKIP_ZERO_EN: steps with multiplier bit 0 == 0 shift without requesting the ALU.
module mult_sequencer #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             alu_req,
   input  logic             alu_gnt,
   output logic [3:0]       alu_ctr,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_cout
);

   localparam int unsigned CNT_W   = $clog2(WIDTH) + 1;
   localparam logic [3:0]  ALU_ADD = 4'b0010;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [CNT_W-1:0] r_cnt;

   logic             w_req;
   logic             w_step;
   logic             w_last;
   logic             w_accept;
   logic             w_top_bit;
   logic [WIDTH-1:0] w_sum;

   // Step request / completion; a step only advances when it owns the adder or needs none
   always_comb begin
      w_req  = 1'b0;
      w_step = 1'b0;
      if (r_state == S_RUN) begin
`ifdef MULT_SKIP_ZERO_EN
         w_req  = r_lo[0];
         w_step = r_lo[0] ? alu_gnt : 1'b1;
`else
         w_req  = 1'b1;
         w_step = alu_gnt;
`endif
      end
   end

   assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
   assign w_accept = (r_state == S_IDLE) && start;

   // Adder-free steps shift in a zero carry and the unchanged upper word
   assign w_top_bit = w_req ? alu_cout   : 1'b0;
   assign w_sum     = w_req ? alu_result : r_hi;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_RUN;
         S_RUN:   if (w_step && w_last) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mcand <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_cnt   <= '0;
      end else if (w_accept) begin
         r_mcand <= op_a;
         r_hi    <= '0;
         r_lo    <= op_b;
         r_cnt   <= '0;
      end else if (w_step) begin
         r_hi    <= {w_top_bit, w_sum[WIDTH-1:1]};
         r_lo    <= {w_sum[0], r_lo[WIDTH-1:1]};
         r_cnt   <= r_cnt + CNT_W'(1);
      end
   end

   assign busy    = (r_state != S_IDLE);
   assign done    = (r_state == S_DONE);
   assign hi      = r_hi;
   assign lo      = r_lo;
   assign alu_req = w_req;
   assign alu_ctr = w_req ? ALU_ADD : 4'b0000;
   assign alu_a   = w_req ? r_hi : '0;
   assign alu_b   = (w_req && r_lo[0]) ? r_mcand : '0;

endmodule
